// File: rtl/vga_pkg.sv
// Shared constants for the VGA scan-out block: default 640x480@60 timing,
// the colour-bar table and a helper that sums a timing axis.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Colour bars as {r,g,b} enables, bar 0 in the least significant slot:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_LUT = {3'b000, 3'b001, 3'b100, 3'b101,
                                     3'b010, 3'b011, 3'b110, 3'b111};

  // Total clocks per line (or lines per frame) for one timing axis.
  function automatic int timing_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a programmable reset value; carries the
// stage-0 timing flags alongside the frame buffer read latency.
module vga_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift the flags one stage per clock.
      // NOTE: every stage is reset, not just the head, so the pins see blank
      // and idle syncs until real counter state has reached the end.
      always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scanout_gen.sv
// Parametrised VGA scan-out: raster counters, incremental frame buffer
// addressing with pixel replication, latency-matched sync/blank and an
// optional colour-bar test pattern latched at frame start.
module vga_scanout_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FRONT    = DEF_V_FRONT,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BACK     = DEF_V_BACK,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   COLOR_W    = 4,
  parameter int   ADDR_W     = 19,
  parameter int   RD_LATENCY = 1,
  parameter int   SCALE_LOG2 = 0
) (
  input  logic                   clk25,
  input  logic                   rst_n,
  input  logic                   test_en,
  output logic [ADDR_W-1:0]      frame_addr,
  input  logic [3*COLOR_W-1:0]   frame_pixel,
  output logic [COLOR_W-1:0]     vga_red,
  output logic [COLOR_W-1:0]     vga_green,
  output logic [COLOR_W-1:0]     vga_blue,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic                   frame_start
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int SW      = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int COLS    = H_ACTIVE >> SCALE_LOG2;

  localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]     H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     HS_BEG   = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0]     HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0]     BAR_LAST = HW'(H_ACTIVE / 8 - 1);
  localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]     V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     VS_BEG   = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0]     VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [SW-1:0]     SUB_MAX  = SW'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

  logic [HW-1:0]     h_cnt, bar_pix;
  logic [VW-1:0]     v_cnt;
  logic [SW-1:0]     h_sub, v_sub;
  logic [ADDR_W-1:0] col, row_base;
  logic [2:0]        bar_idx;
  logic              test_mode;

  logic h_last, v_last, h_vis, v_vis, active, hs, vs, sof;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);
  assign h_vis  = (h_cnt < H_ACT);
  assign v_vis  = (v_cnt < V_ACT);
  assign active = h_vis && v_vis;
  assign hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign sof    = (h_cnt == '0) && (v_cnt == '0);

  // Address is a pure sum of registered terms, so it tracks h_cnt with no
  // extra pipeline stage and no multiplier.
  assign frame_addr = row_base + col;

  // Raster counters: h wraps every line, v advances on each h wrap.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Column advances once per replicated pixel group and parks on the last
  // column through horizontal blanking; row base steps every replicated line.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      h_sub    <= '0;
      row_base <= '0;
      v_sub    <= '0;
    end else begin
      if (h_last) begin
        col   <= '0;
        h_sub <= '0;
      end else if (active) begin
        h_sub <= (h_sub == SUB_MAX) ? '0 : h_sub + SW'(1);
        if (h_sub == SUB_MAX && col != COL_LAST) col <= col + ADDR_W'(1);
      end
      if (h_last) begin
        if (v_last) begin
          row_base <= '0;
          v_sub    <= '0;
        end else if (v_vis) begin
          if (v_sub == SUB_MAX) begin
            v_sub    <= '0;
            row_base <= row_base + ROW_STEP;
          end else begin
            v_sub <= v_sub + SW'(1);
          end
        end
      end
    end
  end

  // Bar index steps every H_ACTIVE/8 visible pixels; test mode is captured
  // only at frame start so a frame is never half bars, half picture.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      bar_pix   <= '0;
      bar_idx   <= '0;
      test_mode <= 1'b0;
    end else begin
      if (h_last) begin
        bar_pix <= '0;
        bar_idx <= '0;
      end else if (h_vis) begin
        if (bar_pix == BAR_LAST) begin
          bar_pix <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pix <= bar_pix + HW'(1);
        end
      end
      if (sof) test_mode <= test_en;
    end
  end

  logic [6:0] dl_in, dl_out;
  logic       d_blank, d_hs, d_vs, d_sof;
  logic [2:0] d_bar;
  logic [2:0] bar_bits;

  assign dl_in = {~active, hs ? HSYNC_POL : ~HSYNC_POL,
                  vs ? VSYNC_POL : ~VSYNC_POL, sof, bar_idx};
  assign {d_blank, d_hs, d_vs, d_sof, d_bar} = dl_out;
  assign bar_bits = BAR_LUT[3*d_bar +: 3];

  vga_delay_line #(
    .DEPTH  (RD_LATENCY),
    .WIDTH  (7),
    .RST_VAL({1'b1, ~HSYNC_POL, ~VSYNC_POL, 1'b0, 3'b000})
  ) u_flags (
    .clk25(clk25),
    .rst_n(rst_n),
    .din  (dl_in),
    .dout (dl_out)
  );

  // Output register: colour, syncs and frame_start leave on the same edge.
  // NOTE: non-blocking assignments here keep every pin sampling the
  // pre-edge pipeline values, so nothing skews by a clock.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      vga_red     <= '0;
      vga_green   <= '0;
      vga_blue    <= '0;
      vga_hsync   <= ~HSYNC_POL;
      vga_vsync   <= ~VSYNC_POL;
      frame_start <= 1'b0;
    end else begin
      vga_hsync   <= d_hs;
      vga_vsync   <= d_vs;
      frame_start <= d_sof;
      if (d_blank) begin
        vga_red   <= '0;
        vga_green <= '0;
        vga_blue  <= '0;
      end else if (test_mode) begin
        vga_red   <= {COLOR_W{bar_bits[2]}};
        vga_green <= {COLOR_W{bar_bits[1]}};
        vga_blue  <= {COLOR_W{bar_bits[0]}};
      end else begin
        vga_red   <= frame_pixel[3*COLOR_W-1:2*COLOR_W];
        vga_green <= frame_pixel[2*COLOR_W-1:COLOR_W];
        vga_blue  <= frame_pixel[COLOR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout_gen.sv
// Bench for vga_scanout_gen: one full-size instance for directed 640x480
// timing checks, three reduced-raster instances scoreboarded every clock.
module tb_vga_scanout_gen;

  // Reduced raster shared by the scoreboarded instances.
  localparam int S_HA = 32, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  localparam exp_t BLANK = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic clk = 1'b0;
  logic rst_n;
  logic test_en_s, te_zero;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  // ---------------- reference helpers ----------------
  function automatic logic [11:0] mem_f(input logic [18:0] a);
    logic [18:0] t;
    t = a ^ (a >> 7) ^ (a >> 12);
    return t[11:0] ^ 12'h5A3;
  endfunction

  function automatic logic [11:0] bar_rgb(input int b);
    case (b)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [18:0] exp_addr(input int h, input int v, input int s);
    return 19'((v >> s) * (S_HA >> s) + (h >> s));
  endfunction

  function automatic exp_t exp_at(input int n, input int s, input logic tm);
    exp_t e;
    int h, v;
    e = BLANK;
    if (n < 0) return e;
    h = n % S_HT;
    v = (n / S_HT) % S_VT;
    e.hs = !(h >= S_HA + S_HF && h < S_HA + S_HF + S_HS);
    e.vs = !(v >= S_VA + S_VF && v < S_VA + S_VF + S_VS);
    e.fs = (h == 0 && v == 0);
    if (h < S_HA && v < S_VA) e.rgb = tm ? bar_rgb(h / (S_HA / 8)) : mem_f(exp_addr(h, v, s));
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- DUTs and frame buffer models ----------------
  logic [18:0] addr_def, addr_l1, addr_l3, addr_s1;
  logic [11:0] pix_def, pix_l1, pix_s1;
  logic [11:0] p3 [3];
  logic [3:0]  r_def, g_def, b_def, r_l1, g_l1, b_l1, r_l3, g_l3, b_l3, r_s1, g_s1, b_s1;
  logic        hs_def, vs_def, fs_def, hs_l1, vs_l1, fs_l1;
  logic        hs_l3, vs_l3, fs_l3, hs_s1, vs_s1, fs_s1;
  logic [11:0] rgb_def, rgb_l1, rgb_l3, rgb_s1;

  assign rgb_def = {r_def, g_def, b_def};
  assign rgb_l1  = {r_l1, g_l1, b_l1};
  assign rgb_l3  = {r_l3, g_l3, b_l3};
  assign rgb_s1  = {r_s1, g_s1, b_s1};

  always @(posedge clk) begin
    pix_def <= mem_f(addr_def);
    pix_l1  <= mem_f(addr_l1);
    pix_s1  <= mem_f(addr_s1);
    p3[0]   <= mem_f(addr_l3);
    p3[1]   <= p3[0];
    p3[2]   <= p3[1];
  end

  vga_scanout_gen u_def (
    .clk25(clk), .rst_n(rst_n), .test_en(te_zero), .frame_addr(addr_def),
    .frame_pixel(pix_def), .vga_red(r_def), .vga_green(g_def), .vga_blue(b_def),
    .vga_hsync(hs_def), .vga_vsync(vs_def), .frame_start(fs_def));

  vga_scanout_gen #(.H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .RD_LATENCY(1)) u_l1 (
    .clk25(clk), .rst_n(rst_n), .test_en(test_en_s), .frame_addr(addr_l1),
    .frame_pixel(pix_l1), .vga_red(r_l1), .vga_green(g_l1), .vga_blue(b_l1),
    .vga_hsync(hs_l1), .vga_vsync(vs_l1), .frame_start(fs_l1));

  vga_scanout_gen #(.H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .RD_LATENCY(3)) u_l3 (
    .clk25(clk), .rst_n(rst_n), .test_en(test_en_s), .frame_addr(addr_l3),
    .frame_pixel(p3[2]), .vga_red(r_l3), .vga_green(g_l3), .vga_blue(b_l3),
    .vga_hsync(hs_l3), .vga_vsync(vs_l3), .frame_start(fs_l3));

  vga_scanout_gen #(.H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .RD_LATENCY(1),
    .SCALE_LOG2(1)) u_s1 (
    .clk25(clk), .rst_n(rst_n), .test_en(te_zero), .frame_addr(addr_s1),
    .frame_pixel(pix_s1), .vga_red(r_s1), .vga_green(g_s1), .vga_blue(b_s1),
    .vga_hsync(hs_s1), .vga_vsync(vs_s1), .frame_start(fs_s1));

  // ---------------- scoreboard ----------------
  // Each negedge pushes the expectation for the current counter index and
  // pops the one whose pixel is due on the pins now (latency + 1 behind).
  exp_t  sb_q [3][$];
  int    lat [3] = '{1, 3, 1};
  int    scl [3] = '{0, 0, 1};
  int    kidx [3];
  logic  tm_m [3];
  string nm [3] = '{"l1", "l3", "s1"};

  task automatic sb_step(input int i, input logic tmi, input logic [11:0] rgb,
                         input logic hs, input logic vs, input logic fs,
                         input logic [18:0] addr);
    exp_t got, e;
    int h, v;
    got = {rgb, hs, vs, fs};
    if (!rst_n) begin
      check({nm[i], "_reset_pins"}, 32'(got), 32'(BLANK));
      check({nm[i], "_reset_addr"}, 32'(addr), 32'd0);
      sb_q[i].delete();
      for (int j = 0; j <= lat[i]; j++) sb_q[i].push_back(BLANK);
      kidx[i] = 0;
      tm_m[i] = 1'b0;
    end else begin
      h = kidx[i] % S_HT;
      v = (kidx[i] / S_HT) % S_VT;
      if (h == 0 && v == 0) tm_m[i] = tmi;
      if (h < S_HA && v < S_VA) check({nm[i], "_addr"}, 32'(addr), 32'(exp_addr(h, v, scl[i])));
      sb_q[i].push_back(exp_at(kidx[i], scl[i], tm_m[i]));
      e = sb_q[i].pop_front();
      check({nm[i], "_pins"}, 32'(got), 32'(e));
      kidx[i]++;
    end
  endtask

  always @(negedge clk) begin
    sb_step(0, test_en_s, rgb_l1, hs_l1, vs_l1, fs_l1, addr_l1);
    sb_step(1, test_en_s, rgb_l3, hs_l3, vs_l3, fs_l3, addr_l3);
    sb_step(2, te_zero,   rgb_s1, hs_s1, vs_s1, fs_s1, addr_s1);
  end

  // ---------------- directed stimulus ----------------
  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) adv();
  endtask

  task automatic check_def_idle(input string tag);
    check({tag, "_rgb"}, 32'(rgb_def), 32'd0);
    check({tag, "_hs"}, 32'(hs_def), 32'd1);
    check({tag, "_vs"}, 32'(vs_def), 32'd1);
    check({tag, "_fs"}, 32'(fs_def), 32'd0);
    check({tag, "_addr"}, 32'(addr_def), 32'd0);
  endtask

  initial begin
    int t0;
    rst_n     = 1'b1;
    test_en_s = 1'b0;
    te_zero   = 1'b0;
    #1 rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_def_idle("def_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    // Full-size timing: frame_start, pixels, hsync position/width/period.
    while (!fs_def && cyc < 20) adv();
    check("def_fs_clock", cyc, 2);
    check("def_px0", 32'(rgb_def), 32'(mem_f(19'd0)));
    adv();
    check("def_fs_pulse", 32'(fs_def), 32'd0);
    wait_to(641);
    check("def_px639", 32'(rgb_def), 32'(mem_f(19'd639)));
    adv();
    check("def_hblank_rgb", 32'(rgb_def), 32'd0);
    while (hs_def && cyc < 1000) adv();
    check("def_hs_start", cyc, 658);
    t0 = cyc;
    while (!hs_def && cyc < 1000) adv();
    check("def_hs_width", cyc - t0, 96);
    check("def_vs_idle", 32'(vs_def), 32'd1);
    wait_to(802);
    check("def_line1_px0", 32'(rgb_def), 32'(mem_f(19'd640)));
    adv();
    check("def_line1_px1", 32'(rgb_def), 32'(mem_f(19'd641)));
    while (hs_def && cyc < 2000) adv();
    check("def_hs_period", cyc, 1458);

    // test_en raised mid-frame 2: frame 2 stays on the frame buffer.
    wait_to(1500);
    test_en_s = 1'b1;
    wait_to(1536);
    check("s1_line2_addr", 32'(addr_s1), 32'd16);
    wait_to(1538);
    check("l1_midframe_fb", 32'(rgb_l1), 32'(mem_f(19'd64)));
    wait_to(1807);
    check("s1_last_addr", 32'(addr_s1), 32'd63);
    wait_to(1809);
    check("s1_last_px", 32'(rgb_s1), 32'(mem_f(19'd63)));

    // Frame 3 shows bars, four pixels wide on the reduced raster.
    wait_to(2162);
    check("l1_bar0", 32'(rgb_l1), 32'h0FFF);
    wait_to(2164);
    check("l3_bar0", 32'(rgb_l3), 32'h0FFF);
    wait_to(2166);
    check("l1_bar1", 32'(rgb_l1), 32'h0FF0);
    wait_to(2168);
    check("l3_bar1", 32'(rgb_l3), 32'h0FF0);
    wait_to(2189);
    check("l1_bar6", 32'(rgb_l1), 32'h000F);
    wait_to(2190);
    check("l1_bar7", 32'(rgb_l1), 32'h0000);
    wait_to(2300);
    test_en_s = 1'b0;

    // Mid-frame reset: pins go idle at once, then the raster restarts.
    wait_to(3130);
    rst_n = 1'b0;
    #1;
    check_def_idle("def_midreset");
    check("l1_midreset_rgb", 32'(rgb_l1), 32'd0);
    check("l1_midreset_hs", 32'(hs_l1), 32'd1);
    test_en_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    while (!fs_def && cyc < 20) adv();
    check("def_fs_after_reset", cyc, 2);
    wait_to(4);
    check("l3_bar0_after_reset", 32'(rgb_l3), 32'h0FFF);
    wait_to(6);
    check("l1_bar1_after_reset", 32'(rgb_l1), 32'h0FF0);
    wait_to(1500);
    test_en_s = 1'b0;
    wait_to(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
